demux1ton_stream: RTL and testbench
===================================

# demux1ton_stream

Parametrised 1-to-N streaming demultiplexer: one DATA_W-bit input stream routed to CH_N output channels, each with valid/ready handshake and a one-entry output register. Generalises the combinational 1-to-4 demux with width/channel parameters, backpressure, an addressed/round-robin mode and invalid-select error reporting. Sits between a single producer and CH_N independent consumers in the datapath.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- CH_N, 4, number of output channels (2..16, need not be a power of two)
- SEL_W, derived localparam = $clog2(CH_N); not overridable

- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- i_data  input  DATA_W  input payload
- i_valid  input  1  input beat present
- o_ready  output  1  input beat accepted this cycle when i_valid=1 (combinational)
- i_sel  input  SEL_W  destination channel in addressed mode
- i_mode  input  1  0 = addressed (MODE_ADDR), 1 = round-robin (MODE_RR)
- o_data  output  CH_N*DATA_W  flattened channel payloads, channel k at [k*DATA_W +: DATA_W]
- o_valid  output  CH_N  per-channel beat present
- i_ready  input  CH_N  per-channel consumer ready
- o_rr_ptr  output  SEL_W  current round-robin destination
- o_err  output  1  registered one-cycle pulse: addressed beat with i_sel ≥ CH_N was dropped

## Operation
- Destination dest = i_sel when i_mode=0, o_rr_ptr when i_mode=1; evaluated every cycle.
- Input handshake: accept = i_valid & o_ready.
- o_ready = 1 if dest invalid (i_sel ≥ CH_N, addressed mode only); else !o_valid[dest] | i_ready[dest].
- Accepted valid-dest beat: slot[dest] loads i_data, o_valid[dest] ← 1.
- Channel drain: o_valid[k] & i_ready[k] clears o_valid[k] unless the same edge loads slot k (simultaneous load+drain: o_valid stays 1, new data).
- Stall: while o_valid[k] & !i_ready[k], o_data[k] holds and o_valid[k] stays 1.
- Idle channels: o_data[k] retains last value; never cleared except by reset.
- Invalid select: beat accepted (o_ready=1), discarded, no slot changes, o_err=1 next cycle; else o_err=0.
- Round-robin pointer: advances by 1 on every accepted beat in mode 1; CH_N-1 wraps to 0. Held in mode 0 and when no beat accepted.
- Mode switch takes effect the same cycle i_mode changes; no flush, slots keep contents.
- o_ready has no dependence on i_valid (no combinational loop via producer).

## Timing
- Reset (async assert, sync-released by upstream): o_valid=0, o_data=0, o_rr_ptr=0, o_err=0; o_ready then equals 1 for any valid dest.
- Reset mid-operation: buffered beats lost, pointer to 0, immediately on i_rst_n low.
- Latency: beat accepted at edge t is visible on o_valid/o_data after edge t (1 cycle).
- Throughput: one beat per cycle into a channel whose consumer holds i_ready=1; round-robin sustains one beat per cycle across channels.
- Combinational paths: i_sel, i_mode, i_ready → o_ready only.

## Structure
- Package demux_pkg: MODE_ADDR=1'b0, MODE_RR=1'b1; function for pointer increment with wrap at CH_N.
- Sub-module demux_slot (DATA_W): one-entry register with load, drain, o_valid/o_data; instantiated CH_N times in a generate loop.
- Top holds dest mux, o_ready logic, round-robin pointer, o_err register.

## Test plan
- Reset: assert i_rst_n=0 with traffic pending → all o_valid=0, o_data=0, o_rr_ptr=0, o_err=0 same cycle.
- Addressed, CH_N=4: i_sel=2, i_data=8'hA5, i_ready=4'b1111 → next cycle o_valid=4'b0100, channel 2 = 8'hA5; others unchanged.
- Backpressure: channel 1 full, i_ready[1]=0, i_sel=1 → o_ready=0, channel 1 holds data; raise i_ready[1] → new beat loads same edge, o_valid[1] stays 1.
- Round-robin wrap, CH_N=3: 4 back-to-back beats 8'h10..8'h13, all ready → channels 0,1,2,0 receive 10,11,12,13; o_rr_ptr 0→1→2→0→1.
- Invalid select, CH_N=3: i_sel=3, i_valid=1 → o_ready=1, no o_valid change, o_err=1 for exactly one cycle.
- Mode switch: mode 1 with o_rr_ptr=2, switch to mode 0 sending 3 beats to i_sel=0, return to mode 1 → next beat goes to channel 2.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the 1-to-N streaming demultiplexer.
//   MODE_ADDR / MODE_RR : encodings of the i_mode input.
//   rr_next()           : round-robin pointer increment with wrap at ch_n.
package demux_pkg;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   // Next round-robin destination; ch_n-1 wraps back to channel 0.
   function automatic int rr_next(input int ptr, input int ch_n);
      return (ptr + 1 >= ch_n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register for a single demux channel.
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (clears valid and data)
//   i_load   write i_data into the slot this edge
//   i_data   payload to load
//   i_ready  consumer ready; drains the slot when no load happens
//   o_valid  slot holds a beat
//   o_data   slot payload (retained after draining)
module demux_slot #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              valid_reg;
   logic [DATA_W-1:0] data_reg;

   // A load wins over a drain, so a simultaneous load+drain keeps valid high
   // with the new payload.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (i_load) begin
         valid_reg <= 1'b1;
         data_reg  <= i_data;
      end else if (i_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign o_valid = valid_reg;
   assign o_data  = data_reg;

endmodule

// File: rtl/demux1ton_stream.sv
// demux1ton_stream: 1-to-CH_N streaming demultiplexer with per-channel
// one-entry output registers, addressed or round-robin routing and
// invalid-select error reporting.
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_data    input payload
//   i_valid   input beat present
//   o_ready   input beat accepted when i_valid=1 (combinational)
//   i_sel     destination in addressed mode
//   i_mode    0 = addressed, 1 = round-robin
//   o_data    flattened channel payloads, channel k at [k*DATA_W +: DATA_W]
//   o_valid   per-channel beat present
//   i_ready   per-channel consumer ready
//   o_rr_ptr  current round-robin destination
//   o_err     one-cycle pulse after an addressed beat with i_sel >= CH_N was dropped
module demux1ton_stream
   import demux_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int CH_N   = 4,
   localparam int SEL_W  = $clog2(CH_N)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [DATA_W-1:0]      i_data,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [SEL_W-1:0]       i_sel,
   input  logic                   i_mode,
   output logic [CH_N*DATA_W-1:0] o_data,
   output logic [CH_N-1:0]        o_valid,
   input  logic [CH_N-1:0]        i_ready,
   output logic [SEL_W-1:0]       o_rr_ptr,
   output logic                   o_err
);

   logic [SEL_W-1:0] dest;
   logic [SEL_W-1:0] rr_ptr_reg;
   logic [SEL_W-1:0] rr_ptr_next;
   logic             dest_ok;
   logic             ready_sel;
   logic             accept;
   logic             err_reg;
   logic [CH_N-1:0]  load;
   logic [CH_N-1:0]  slot_valid;

   // The round-robin pointer is always in range, so only an addressed
   // select can name a channel that does not exist.
   always_comb begin
      dest    = (i_mode == MODE_RR) ? rr_ptr_reg : i_sel;
      dest_ok = (i_mode == MODE_RR) || (int'(i_sel) < CH_N);
   end

   // Space in the selected slot: empty, or being drained this edge.
   always_comb begin
      ready_sel = 1'b0;
      for (int k = 0; k < CH_N; k++) begin
         if (int'(dest) == k) begin
            ready_sel = !slot_valid[k] | i_ready[k];
         end
      end
   end

   // Invalid-select beats are swallowed so the producer never stalls on them.
   assign o_ready = !dest_ok | ready_sel;
   assign accept  = i_valid & o_ready;

   generate
      for (genvar gi = 0; gi < CH_N; gi++) begin : g_slot
         assign load[gi] = accept & dest_ok & (int'(dest) == gi);

         demux_slot #(
            .DATA_W (DATA_W)
         ) u_slot (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (load[gi]),
            .i_data  (i_data),
            .i_ready (i_ready[gi]),
            .o_valid (slot_valid[gi]),
            .o_data  (o_data[gi*DATA_W +: DATA_W])
         );
      end
   endgenerate

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (accept && (i_mode == MODE_RR)) begin
         rr_ptr_next = SEL_W'(rr_next(int'(rr_ptr_reg), CH_N));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         err_reg    <= accept & !dest_ok;
      end
   end

   assign o_valid  = slot_valid;
   assign o_rr_ptr = rr_ptr_reg;
   assign o_err    = err_reg;

endmodule

// File: tb/tb_demux1ton_stream.sv
// tb_demux1ton_stream: directed bench for demux1ton_stream with DATA_W=8,
// CH_N=3 (non-power-of-two so i_sel=3 is an invalid select).
module tb_demux1ton_stream;

   localparam int DATA_W = 8;
   localparam int CH_N   = 3;
   localparam int SEL_W  = 2;

   logic                   clk;
   logic                   rst_n;
   logic [DATA_W-1:0]      data;
   logic                   valid;
   logic                   ready_out;
   logic [SEL_W-1:0]       sel;
   logic                   mode;
   logic [CH_N*DATA_W-1:0] data_out;
   logic [CH_N-1:0]        valid_out;
   logic [CH_N-1:0]        ready_in;
   logic [SEL_W-1:0]       rr_ptr;
   logic                   err;

   int total = 0;
   int bad   = 0;

   demux1ton_stream #(
      .DATA_W (DATA_W),
      .CH_N   (CH_N)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_data   (data),
      .i_valid  (valid),
      .o_ready  (ready_out),
      .i_sel    (sel),
      .i_mode   (mode),
      .o_data   (data_out),
      .o_valid  (valid_out),
      .i_ready  (ready_in),
      .o_rr_ptr (rr_ptr),
      .o_err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      data     = 8'hFF;
      valid    = 1'b1;
      sel      = 2'd0;
      mode     = 1'b0;
      ready_in = 3'b000;

      // Reset held across edges with a beat pending: nothing may load.
      #12;
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_data",  32'(data_out),  32'h0);
      chk("rst_ptr",   32'(rr_ptr),    32'h0);
      chk("rst_err",   32'(err),       32'h0);
      chk("rst_ready", 32'(ready_out), 32'h1);
      valid = 1'b0;
      #1 rst_n = 1'b1;

      // Addressed beat to channel 2.
      tick();
      ready_in = 3'b111; sel = 2'd2; data = 8'hA5; valid = 1'b1;
      #1 chk("addr_ready", 32'(ready_out), 32'h1);
      tick();
      valid = 1'b0;
      chk("addr_valid", 32'(valid_out), 32'h4);
      chk("addr_data",  32'(data_out),  32'hA50000);
      chk("addr_ptr",   32'(rr_ptr),    32'h0);
      tick();
      chk("drain_valid", 32'(valid_out), 32'h0);
      chk("idle_data",   32'(data_out),  32'hA50000);

      // Backpressure on channel 1.
      ready_in = 3'b000; sel = 2'd1; data = 8'h3C; valid = 1'b1;
      tick();
      chk("bp_load_valid", 32'(valid_out), 32'h2);
      chk("bp_load_data",  32'(data_out),  32'hA53C00);
      data = 8'h77;
      #1 chk("bp_ready_low", 32'(ready_out), 32'h0);
      tick();
      chk("bp_hold_valid", 32'(valid_out), 32'h2);
      chk("bp_hold_data",  32'(data_out),  32'hA53C00);
      ready_in = 3'b010;
      #1 chk("bp_ready_high", 32'(ready_out), 32'h1);
      tick();
      chk("bp_swap_valid", 32'(valid_out), 32'h2);
      chk("bp_swap_data",  32'(data_out),  32'hA57700);
      valid = 1'b0; ready_in = 3'b111;
      tick();
      chk("bp_drained", 32'(valid_out), 32'h0);

      // Invalid select: swallowed even with every consumer stalled.
      ready_in = 3'b000; sel = 2'd3; data = 8'hEE; valid = 1'b1;
      #1 chk("inv_ready", 32'(ready_out), 32'h1);
      tick();
      valid = 1'b0;
      chk("inv_err",   32'(err),       32'h1);
      chk("inv_valid", 32'(valid_out), 32'h0);
      chk("inv_data",  32'(data_out),  32'hA57700);
      tick();
      chk("inv_err_clr", 32'(err), 32'h0);

      // Round-robin wrap over 3 channels.
      mode = 1'b1; ready_in = 3'b111; valid = 1'b1;
      data = 8'h10;
      #1 chk("rr0_ptr", 32'(rr_ptr), 32'h0);
      tick();
      chk("rr0_valid", 32'(valid_out), 32'h1);
      chk("rr0_ptr_after", 32'(rr_ptr), 32'h1);
      data = 8'h11;
      tick();
      chk("rr1_valid", 32'(valid_out), 32'h2);
      chk("rr1_ptr_after", 32'(rr_ptr), 32'h2);
      data = 8'h12;
      tick();
      chk("rr2_valid", 32'(valid_out), 32'h4);
      chk("rr2_ptr_after", 32'(rr_ptr), 32'h0);
      data = 8'h13;
      tick();
      chk("rr3_valid", 32'(valid_out), 32'h1);
      chk("rr3_ptr_after", 32'(rr_ptr), 32'h1);
      chk("rr3_data",  32'(data_out),  32'h121113);
      valid = 1'b0;
      tick();
      chk("rr_idle_ptr", 32'(rr_ptr), 32'h1);

      // Mode switch: bring pointer to 2, send addressed beats, return.
      valid = 1'b1; data = 8'h14;
      tick();
      chk("ms_ptr2", 32'(rr_ptr), 32'h2);
      mode = 1'b0; sel = 2'd0;
      data = 8'h20; tick();
      data = 8'h21; tick();
      data = 8'h22; tick();
      chk("ms_addr_valid", 32'(valid_out), 32'h1);
      chk("ms_ptr_held",   32'(rr_ptr),    32'h2);
      mode = 1'b1; data = 8'h30;
      tick();
      chk("ms_rr_valid", 32'(valid_out), 32'h4);
      chk("ms_rr_data",  32'(data_out),  32'h301422);
      chk("ms_rr_ptr",   32'(rr_ptr),    32'h0);

      // Load with stalled consumers, then async reset mid-cycle.
      ready_in = 3'b000; data = 8'h40;
      tick();
      valid = 1'b0;
      chk("pre_rst_valid", 32'(valid_out), 32'h5);
      chk("pre_rst_ptr",   32'(rr_ptr),    32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_out), 32'h0);
      chk("arst_data",  32'(data_out),  32'h0);
      chk("arst_ptr",   32'(rr_ptr),    32'h0);
      chk("arst_err",   32'(err),       32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
